cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl.sv | 174 +++++++++++++++++
 tb/tb_cache_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// Two-way set-associative cache controller: tag lookup, LRU victim choice,
// 8-word refill burst from memory and tag-store update.
module cache_ctrl #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [24:0] cpu_addr,
  output logic        busy,
  output logic        cpu_ready,
  output logic        cpu_hit,
  output logic        cpu_way,
  output logic [6:0]  tag_set_addr,
  output logic        tag_we,
  output logic        tag_set_element,
  output logic [12:0] tag_in,
  output logic        valid_in,
  input  logic [12:0] tag_out0,
  input  logic [12:0] tag_out1,
  input  logic        valid_out0,
  input  logic        valid_out1,
  output logic        mem_req,
  output logic [24:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_word_valid,
  output logic        data_we,
  output logic [10:0] data_addr
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_FILL   = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [2:0] LAST_WORD = 3'(BLOCK_WORDS - 1);

  logic [2:0]   state_q, state_d;
  logic [12:0]  tag_q, tag_d;
  logic [6:0]   idx_q, idx_d;
  logic         victim_q, victim_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [127:0] lru_q, lru_d;

  logic        hit0, hit1;
  logic        busy_c, ready_c, hit_c, way_c;
  logic [6:0]  set_addr_c;
  logic        tag_we_c, elem_c, valid_in_c;
  logic [12:0] tag_in_c;
  logic        mem_req_c, data_we_c;
  logic [24:0] mem_addr_c;
  logic [10:0] data_addr_c;

  assign hit0 = valid_out0 && (tag_out0 == tag_q);
  assign hit1 = valid_out1 && (tag_out1 == tag_q);

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    idx_d       = idx_q;
    victim_d    = victim_q;
    cnt_d       = cnt_q;
    lru_d       = lru_q;
    busy_c      = 1'b0;
    ready_c     = 1'b0;
    hit_c       = 1'b0;
    way_c       = 1'b0;
    set_addr_c  = idx_q;
    tag_we_c    = 1'b0;
    elem_c      = 1'b0;
    tag_in_c    = '0;
    valid_in_c  = 1'b0;
    mem_req_c   = 1'b0;
    mem_addr_c  = '0;
    data_we_c   = 1'b0;
    data_addr_c = '0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          // Present the incoming index now so tag data is ready in LOOKUP.
          tag_d      = cpu_addr[24:12];
          idx_d      = cpu_addr[11:5];
          set_addr_c = cpu_addr[11:5];
          cnt_d      = '0;
          state_d    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        busy_c = 1'b1;
        if (hit0 || hit1) begin
          ready_c       = 1'b1;
          hit_c         = 1'b1;
          way_c         = ~hit0;
          lru_d[idx_q]  = hit0;
          state_d       = S_IDLE;
        end else begin
          // Prefer an empty way; fall back to the least recently used one.
          if (!valid_out0)      victim_d = 1'b0;
          else if (!valid_out1) victim_d = 1'b1;
          else                  victim_d = lru_q[idx_q];
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        busy_c     = 1'b1;
        mem_req_c  = 1'b1;
        mem_addr_c = {tag_q, idx_q, 5'b0};
        cnt_d      = '0;
        if (mem_ack) state_d = S_FILL;
      end
      S_FILL: begin
        busy_c      = 1'b1;
        data_addr_c = {victim_q, idx_q, cnt_q};
        if (mem_word_valid) begin
          data_we_c = 1'b1;
          cnt_d     = cnt_q + 3'd1;
          if (cnt_q == LAST_WORD) state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        busy_c          = 1'b1;
        tag_we_c        = 1'b1;
        elem_c          = victim_q;
        tag_in_c        = tag_q;
        valid_in_c      = 1'b1;
        lru_d[idx_q]    = ~victim_q;
        state_d         = S_DONE;
      end
      S_DONE: begin
        busy_c  = 1'b1;
        ready_c = 1'b1;
        way_c   = victim_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tag_q    <= '0;
      idx_q    <= '0;
      victim_q <= 1'b0;
      cnt_q    <= '0;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      idx_q    <= idx_d;
      victim_q <= victim_d;
      cnt_q    <= cnt_d;
      lru_q    <= lru_d;
    end
  end

  // Outputs are forced quiet while reset is held, whatever state is still registered.
  assign busy            = busy_c & ~rst;
  assign cpu_ready       = ready_c & ~rst;
  assign cpu_hit         = hit_c & ~rst;
  assign cpu_way         = way_c & ~rst;
  assign tag_set_addr    = rst ? '0 : set_addr_c;
  assign tag_we          = tag_we_c & ~rst;
  assign tag_set_element = elem_c & ~rst;
  assign tag_in          = rst ? '0 : tag_in_c;
  assign valid_in        = valid_in_c & ~rst;
  assign mem_req         = mem_req_c & ~rst;
  assign mem_addr        = rst ? '0 : mem_addr_c;
  assign data_we         = data_we_c & ~rst;
  assign data_addr       = rst ? '0 : data_addr_c;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural two-way tag store and a
// memory responder driven from the access task.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [24:0] cpu_addr;
  logic        busy, cpu_ready, cpu_hit, cpu_way;
  logic [6:0]  tag_set_addr;
  logic        tag_we, tag_set_element, valid_in;
  logic [12:0] tag_in;
  logic [12:0] tag_out0, tag_out1;
  logic        valid_out0, valid_out1;
  logic        mem_req;
  logic [24:0] mem_addr;
  logic        mem_ack, mem_word_valid;
  logic        data_we;
  logic [10:0] data_addr;

  int total = 0;
  int bad   = 0;

  cache_ctrl #(.BLOCK_WORDS(8)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .busy(busy), .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .cpu_way(cpu_way),
    .tag_set_addr(tag_set_addr), .tag_we(tag_we), .tag_set_element(tag_set_element),
    .tag_in(tag_in), .valid_in(valid_in),
    .tag_out0(tag_out0), .tag_out1(tag_out1),
    .valid_out0(valid_out0), .valid_out1(valid_out1),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_word_valid(mem_word_valid), .data_we(data_we), .data_addr(data_addr)
  );

  always #5 clk = ~clk;

  // Tag store: registered read, write-first on the same set.
  logic [12:0]  tmem0 [128];
  logic [12:0]  tmem1 [128];
  logic [127:0] tv0 = '0;
  logic [127:0] tv1 = '0;

  always @(posedge clk) begin
    if (tag_we && !tag_set_element) begin tmem0[tag_set_addr] <= tag_in; tv0[tag_set_addr] <= valid_in; end
    if (tag_we &&  tag_set_element) begin tmem1[tag_set_addr] <= tag_in; tv1[tag_set_addr] <= valid_in; end
    tag_out0   <= (tag_we && !tag_set_element) ? tag_in   : tmem0[tag_set_addr];
    valid_out0 <= (tag_we && !tag_set_element) ? valid_in : tv0[tag_set_addr];
    tag_out1   <= (tag_we &&  tag_set_element) ? tag_in   : tmem1[tag_set_addr];
    valid_out1 <= (tag_we &&  tag_set_element) ? valid_in : tv1[tag_set_addr];
  end

  task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tg, obs, exp);
    end
  endtask

  task automatic zero_chk(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_ready"}, cpu_ready, 0);
    chk({pfx, "_hit"}, cpu_hit, 0);
    chk({pfx, "_way"}, cpu_way, 0);
    chk({pfx, "_tag_we"}, tag_we, 0);
    chk({pfx, "_valid_in"}, valid_in, 0);
    chk({pfx, "_mem_req"}, mem_req, 0);
    chk({pfx, "_data_we"}, data_we, 0);
    chk({pfx, "_set_addr"}, tag_set_addr, 0);
    chk({pfx, "_mem_addr"}, mem_addr, 0);
    chk({pfx, "_data_addr"}, data_addr, 0);
  endtask

  // One CPU access; the bench plays memory (ack on the 2nd request cycle,
  // a word every 'gap' cycles) and checks every refill side effect.
  task automatic access(input logic [24:0] a, input bit exp_hit, input bit exp_way,
                        input int gap, input bit hold, input bit pre);
    int cyc = 1, reqc = 0, bursts = 0, words = 0, tw = 0, gc = 0;
    bit filling = 0, done = 0, prev_req = 0, got_hit = 0, got_way = 0;
    logic [12:0] t;
    logic [6:0]  ix;
    t  = a[24:12];
    ix = a[11:5];
    if (!pre) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_addr = a; mem_ack = 1'b0; mem_word_valid = 1'b0;
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_set_addr", tag_set_addr, ix);
    end
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      cpu_req = hold;
      if (!hold) cpu_addr = a ^ 25'h0ABCDE4;
      mem_ack = 1'b0; mem_word_valid = 1'b0;
      if (mem_req) begin
        if (!prev_req) bursts++;
        prev_req = 1;
        reqc++;
        if (reqc == 1) mem_word_valid = 1'b1;
        if (reqc == 2) mem_ack = 1'b1;
      end else prev_req = 0;
      if (filling && words < 8) begin
        gc++;
        if (gc % gap == 0) mem_word_valid = 1'b1;
      end
      #1;
      chk("busy", busy, 1);
      if (mem_req) chk("mem_addr", mem_addr, {t, ix, 5'b0});
      if (data_we) begin
        chk("data_addr", data_addr, {exp_way, ix, words[2:0]});
        words++;
      end
      if (tag_we) begin
        tw++;
        chk("tag_elem", tag_set_element, exp_way);
        chk("tag_in", tag_in, t);
        chk("valid_in", valid_in, 1);
        chk("tag_set_addr", tag_set_addr, ix);
        chk("tag_we_after_8", words, 8);
      end
      if (cpu_ready) begin done = 1; got_hit = cpu_hit; got_way = cpu_way; end
      if (mem_ack && mem_req) filling = 1;
    end
    chk("ready_seen", done, 1);
    chk("cpu_hit", got_hit, exp_hit);
    chk("cpu_way", got_way, exp_way);
    if (exp_hit) chk("hit_latency", cyc, 2);
    chk("mem_bursts", bursts, exp_hit ? 0 : 1);
    chk("data_writes", words, exp_hit ? 0 : 8);
    chk("tag_writes", tw, exp_hit ? 0 : 1);
    if (hold) begin
      @(negedge clk);
      #1;
      chk("hold_idle_busy", busy, 0);
    end
  endtask

  localparam logic [24:0] A1 = {13'h0001, 7'd1, 5'd0};
  localparam logic [24:0] A2 = {13'h0002, 7'd1, 5'd4};
  localparam logic [24:0] A3 = {13'h0003, 7'd1, 5'd8};
  localparam logic [24:0] A5 = {13'h1F5A, 7'h7F, 5'd12};
  localparam logic [24:0] A7 = {13'h0777, 7'd2, 5'd0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w, sw, st, sr;
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; mem_ack = 1'b0; mem_word_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 zero_chk("in_rst");
    @(negedge clk); rst = 1'b0;
    #1 zero_chk("post_rst");

    access(A1, 0, 0, 1, 0, 0);
    access(A1, 1, 0, 1, 0, 0);
    access(A2, 0, 1, 1, 0, 0);
    access(A3, 0, 0, 3, 0, 0);
    access(A1, 0, 1, 1, 0, 0);
    access(A3, 1, 0, 1, 0, 0);
    access(A2, 0, 1, 2, 1, 0);
    access(A2, 1, 1, 1, 0, 1);
    access(A5, 0, 0, 2, 0, 0);

    // Abort a refill after four words with reset.
    @(negedge clk); cpu_req = 1'b1; cpu_addr = A7;
    @(negedge clk); cpu_req = 1'b0;
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    chk("abort_mem_req", mem_req, 1);
    mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0;
    w = 0;
    repeat (4) begin
      mem_word_valid = 1'b1;
      #1;
      chk("abort_data_addr", data_addr, {1'b0, 7'd2, w[2:0]});
      if (data_we) w++;
      @(negedge clk);
    end
    chk("abort_words", w, 4);
    mem_word_valid = 1'b0; rst = 1'b1;
    #1 zero_chk("abort_in_rst");
    @(negedge clk); rst = 1'b0; mem_word_valid = 1'b1;
    #1 zero_chk("abort_post_rst");
    sw = 0; st = 0; sr = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mem_word_valid = i[0]; mem_ack = ~i[0];
      #1;
      sw += int'(data_we); st += int'(tag_we); sr += int'(cpu_ready | busy);
    end
    mem_word_valid = 1'b0; mem_ack = 1'b0;
    chk("stray_data_we", sw, 0);
    chk("stray_tag_we", st, 0);
    chk("stray_ready_busy", sr, 0);

    access(A7, 0, 0, 1, 0, 0);
    access(A1, 0, 0, 1, 0, 0);
    access(A2, 1, 1, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
